opsum_postproc: RTL

- Downstream consumer of the convolution unit's OPSUM FIFO pop stream; one instance serves one output channel stream at a time.
- Per 32-bit partial sum: optional bias add, optional ReLU, fixed-point requant by quant_scale, saturate to int8.
- Packs four int8 results per 32-bit word and writes them into the Global Buffer (GLB) at an incrementing address.
- Controlled per tile by the DLA controller through start/flush/done.

---
 rtl/dla_pkg.sv | 22 ++
 rtl/opsum_postproc_if.sv | 35 +++
 rtl/opsum_postproc_requant_sat.sv | 31 +++
 rtl/opsum_postproc.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dla_pkg.sv
// Shared DLA definitions: flag bit positions, int8 limits, GLB write-enable idle value, postproc FSM states.
package dla_pkg;

    localparam int FLAG_RELU   = 0;
    localparam int FLAG_BIAS   = 3;

    localparam int INT8_MAX    = 127;
    localparam int INT8_MIN    = -128;

    localparam logic [3:0] GLB_WEB_NONE = 4'b1111;

    // Psum acceptance to packed byte; the pipeline structure is fixed.
    localparam int PIPE_STAGES = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } pp_state_e;

endpackage

// File: rtl/opsum_postproc_if.sv
// Control, psum pop stream and GLB write port of the opsum post-processor.
// master = DLA controller / OPSUM FIFO / GLB side, slave = the post-processor.
interface opsum_postproc_if #(
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             flush_i;
    logic [31:0]      base_addr_i;
    logic [3:0]       flags_i;
    logic [7:0]       quant_scale_i;
    logic [31:0]      bias_i;
    logic             psum_valid_i;
    logic [31:0]      psum_data_i;
    logic             psum_ready_o;
    logic [31:0]      glb_addr_o;
    logic [31:0]      glb_write_data_o;
    logic [3:0]       glb_web_o;
    logic [CNT_W-1:0] words_written_o;
    logic             busy_o;
    logic             done_o;

    modport master (
        output start_i, flush_i, base_addr_i, flags_i, quant_scale_i, bias_i,
        output psum_valid_i, psum_data_i,
        input  psum_ready_o, glb_addr_o, glb_write_data_o, glb_web_o,
        input  words_written_o, busy_o, done_o
    );

    modport slave (
        input  start_i, flush_i, base_addr_i, flags_i, quant_scale_i, bias_i,
        input  psum_valid_i, psum_data_i,
        output psum_ready_o, glb_addr_o, glb_write_data_o, glb_web_o,
        output words_written_o, busy_o, done_o
    );
endinterface

// File: rtl/opsum_postproc_requant_sat.sv
// Requantise: signed 32-bit value times unsigned scale, round half up, arithmetic shift, saturate to int8.
// Latency: combinational. Backpressure: none.
// Product fits in 41 bits signed, so no intermediate overflow is possible.
module requant_sat
    import dla_pkg::*;
#(
    parameter int SCALE_SHIFT = 8
) (
    input  logic signed [31:0] val,
    input  logic        [7:0]  scale,
    output logic        [7:0]  q
);

    logic signed [40:0] prod;
    logic signed [40:0] rnd;
    logic signed [40:0] shr;

    always_comb begin
        prod = 41'(val) * $signed({33'd0, scale});
        rnd  = prod + (41'sd1 <<< (SCALE_SHIFT - 1));
        shr  = rnd >>> SCALE_SHIFT;
        if (shr > 41'(INT8_MAX)) begin
            q = 8'(INT8_MAX);
        end else if (shr < 41'(INT8_MIN)) begin
            q = 8'(INT8_MIN);
        end else begin
            q = shr[7:0];
        end
    end

endmodule

// File: rtl/opsum_postproc.sv
// Opsum post-processor: bias, ReLU, requant to int8, pack 4 bytes per GLB word, tile control via start/flush/done.
// Latency: 3 stages to packed byte; GLB write registered, 4 cycles after the 4th psum is accepted.
// Backpressure: psum_ready_o only in RUN; GLB side has none (one write per cycle always accepted).
module opsum_postproc
    import dla_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SCALE_SHIFT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    opsum_postproc_if.slave  bus
);

    pp_state_e          state_q, state_d;
    logic               psum_rdy, busy, done, flush_wr, tile_start;
    logic               accept, pipe_empty;

    logic               s1_vld, s2_vld, s3_vld;
    logic        [31:0] s1_dat;
    logic signed [31:0] s2_dat;
    logic        [7:0]  s3_dat, rq_dat;
    logic        [32:0] sum33;
    logic        [31:0] s1_sat;

    logic        [1:0]  lane_q;
    logic        [31:0] hold_q, addr_q;
    logic [CNT_W-1:0]   words_q;
    logic        [31:0] glb_addr_q, glb_data_q;
    logic        [3:0]  glb_web_q, partial_web;
    logic               flags_unused;

    assign flags_unused = ^bus.flags_i[2:1];
    assign accept       = bus.psum_valid_i && psum_rdy;
    assign pipe_empty   = !(s1_vld || s2_vld || s3_vld);
    assign partial_web  = ~(4'(4'b0001 << lane_q) - 4'd1);

    always_comb begin
        sum33 = {bus.psum_data_i[31], bus.psum_data_i}
              + (bus.flags_i[FLAG_BIAS] ? {bus.bias_i[31], bus.bias_i} : 33'd0);
        // Sign bits disagree only on 32-bit overflow; clamp toward the overflow direction.
        if (sum33[32] != sum33[31]) begin
            s1_sat = sum33[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            s1_sat = sum33[31:0];
        end
    end

    requant_sat #(.SCALE_SHIFT(SCALE_SHIFT)) u_requant (
        .val   (s2_dat),
        .scale (bus.quant_scale_i),
        .q     (rq_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        psum_rdy   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        flush_wr   = 1'b0;
        tile_start = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (bus.start_i) begin
                    tile_start = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                psum_rdy = 1'b1;
                if (bus.flush_i) state_d = FLUSH;
            end
            FLUSH: begin
                if (pipe_empty) begin
                    flush_wr = (lane_q != 2'd0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            s3_vld     <= 1'b0;
            s1_dat     <= '0;
            s2_dat     <= '0;
            s3_dat     <= '0;
            lane_q     <= '0;
            hold_q     <= '0;
            addr_q     <= '0;
            words_q    <= '0;
            glb_addr_q <= '0;
            glb_data_q <= '0;
            glb_web_q  <= GLB_WEB_NONE;
        end else begin
            s1_vld <= accept;
            s2_vld <= s1_vld;
            s3_vld <= s2_vld;
            if (accept) s1_dat <= s1_sat;
            if (s1_vld) s2_dat <= (bus.flags_i[FLAG_RELU] && s1_dat[31]) ? 32'sd0 : $signed(s1_dat);
            if (s2_vld) s3_dat <= rq_dat;

            glb_web_q <= GLB_WEB_NONE;
            if (tile_start) begin
                addr_q  <= bus.base_addr_i;
                lane_q  <= '0;
                words_q <= '0;
                hold_q  <= '0;
            end else if (s3_vld) begin
                if (lane_q == 2'd3) begin
                    glb_data_q <= {s3_dat, hold_q[23:0]};
                    glb_web_q  <= 4'b0000;
                    glb_addr_q <= addr_q;
                    addr_q     <= addr_q + 32'd4;
                    words_q    <= words_q + CNT_W'(1);
                    lane_q     <= '0;
                    hold_q     <= '0;
                end else begin
                    hold_q[{lane_q, 3'b000} +: 8] <= s3_dat;
                    lane_q                        <= lane_q + 2'd1;
                end
            end else if (flush_wr) begin
                // Unfilled lanes are already zero because hold_q clears on every write.
                glb_data_q <= hold_q;
                glb_web_q  <= partial_web;
                glb_addr_q <= addr_q;
                addr_q     <= addr_q + 32'd4;
                words_q    <= words_q + CNT_W'(1);
                lane_q     <= '0;
                hold_q     <= '0;
            end
        end
    end

    assign bus.psum_ready_o     = psum_rdy;
    assign bus.busy_o           = busy;
    assign bus.done_o           = done;
    assign bus.glb_addr_o       = glb_addr_q;
    assign bus.glb_write_data_o = glb_data_q;
    assign bus.glb_web_o        = glb_web_q;
    assign bus.words_written_o  = words_q;

endmodule
